mvm_run_sequencer: RTL and testbench
====================================

Name: mvm_run_sequencer

Overview:
- Sits directly downstream of the matrix-vector compute top: drives its active-low reset_n and consumes its sum/cycle/done outputs.
- Sequences N back-to-back compute runs: holds the core in reset, releases it, waits for done, then captures {run index, cycle count, sum}.
- Buffers captured results in a small FWFT FIFO and streams them out over valid/ready toward the HPS bridge.

Parameters:
- SUM_W, 24, width of core sum
- CYC_W, 10, width of core cycle counter
- RUNS_W, 8, width of run count/index
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
- RST_CYCLES, 2, cycles core_reset_n held low before each run (>=1)
- TIMEOUT, 1023, max WAIT cycles per run (used only with RUN_TIMEOUT_EN)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a batch
- num_runs  in  RUNS_W  runs in batch, latched on accepted start
- core_reset_n  out  1  drives compute core reset_n
- core_sum  in  SUM_W  core result
- core_cycle  in  CYC_W  core cycle count
- core_done  in  1  core done level
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  RUNS_W+CYC_W+SUM_W  {run_idx, cycle, sum}, MSB first
- busy  out  1  batch in progress
- run_complete  out  1  one-cycle pulse at batch end
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Reset values: core_reset_n=0, res_valid=0, res_data=0, busy=0, run_complete=0, timeout_err=0.
  - FIFO flushed, run_idx=0, state=IDLE.
  - Reset mid-operation aborts the batch; no partial entry is pushed.
- FSM states: IDLE, HOLD, WAIT, FULLW.
  - IDLE:
    - core_reset_n=0.
    - start=1 with num_runs!=0 is accepted: latch num_runs, run_idx=0, busy=1, clear timeout_err, go to HOLD.
    - start with num_runs=0 is ignored.
  - HOLD:
    - core_reset_n=0 for exactly RST_CYCLES cycles (down-counter), then WAIT.
    - core_reset_n is a registered output; it reads 1 from the first WAIT cycle.
  - WAIT:
    - core_reset_n=1; registered done_q tracks core_done.
    - Capture event = core_done & ~done_q.
    - On a capture event with FIFO not full (count<FIFO_DEPTH at cycle start): push {run_idx, core_cycle, core_sum} that cycle.
    - On a capture event with FIFO full: go to FULLW.
  - FULLW:
    - core_reset_n stays 1, so the core holds sum/done stable.
    - Push on the first cycle count<FIFO_DEPTH at cycle start.
    - A pop in the same cycle frees space only from the next cycle.
  - After each push:
    - If run_idx==num_runs-1: go to IDLE, busy=0, run_complete=1 for one cycle.
    - Otherwise: run_idx+1, go to HOLD.
- start while busy=1 is ignored.
- FIFO:
  - FWFT; res_valid = count!=0; res_data = head entry (0 when empty).
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - No entry is ever dropped or overwritten.
- Latency: capture event in cycle t with FIFO empty -> res_valid=1 with that data in cycle t+1.
- Width rules: fields are concatenated unmodified; run_idx counts 0..num_runs-1 and never wraps within a batch.

Optional Feature:
- Macro: RUN_TIMEOUT_EN.
- Defined:
  - WAIT cycle counter, cleared on entry to WAIT.
  - If it reaches TIMEOUT with no capture event: set timeout_err (sticky until the next accepted start), push nothing, return to IDLE with core_reset_n=0, busy=0, run_complete pulse.
  - The FULLW state is not timed.
- Undefined: WAIT waits indefinitely; timeout_err tied to 0.

Test Plan:
1. start, num_runs=1; core model raises done 200 cycles after release with sum=24'h00ABCD, cycle=10'h0C8 -> core_reset_n low exactly 2 cycles; res_valid next cycle with res_data={8'd0,10'h0C8,24'h00ABCD}; run_complete pulse; busy falls.
2. num_runs=6, res_ready=0 -> 4 entries queued; 5th done parks in FULLW with core_reset_n=1; res_ready=1 -> all 6 drained in order, run_idx 0..5, sums intact.
3. start with num_runs=0 -> busy, core_reset_n and res_valid unchanged; start pulsed during an active batch -> ignored, batch count unaffected.
4. reset asserted in WAIT of run 2 -> next edge: all outputs at reset values, FIFO empty; a new start then behaves as in test 1.
5. res_ready held 1, num_runs=3, short core runs -> simultaneous push/pop exercised; count never exceeds 1; 3 entries, no loss.
6. RUN_TIMEOUT_EN, TIMEOUT=50, core never raises done -> timeout_err=1 after 50 WAIT cycles, IDLE, no FIFO entry; without macro busy stays 1 and timeout_err stays 0.

Source files
------------

// File: rtl/mvm_run_sequencer.sv
// Runs the matrix-vector core N times back to back and streams {run_idx, cycle, sum} through a FWFT FIFO.
// Optional build macro RUN_TIMEOUT_EN adds a per-run WAIT watchdog that aborts the batch.
module mvm_run_sequencer #(
  parameter int SUM_W      = 24,
  parameter int CYC_W      = 10,
  parameter int RUNS_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [RUNS_W-1:0]               num_runs,
  output logic                            core_reset_n,
  input  logic [SUM_W-1:0]                core_sum,
  input  logic [CYC_W-1:0]                core_cycle,
  input  logic                            core_done,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [RUNS_W+CYC_W+SUM_W-1:0]   res_data,
  output logic                            busy,
  output logic                            run_complete,
  output logic                            timeout_err,
  output logic [1:0]                      dbg_state
);

  localparam int DATA_W = RUNS_W + CYC_W + SUM_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, WAIT = 2'd2, FULLW = 2'd3} state_t;

  // Handshake: an entry moves out on a cycle where res_valid and res_ready are both high;
  // res_data is stable while res_valid is high and res_ready is low.

  state_t              state_q, state_d;
  logic [RUNS_W-1:0]   num_q, run_idx_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                done_q;
  logic                core_rst_n_q;
  logic                run_complete_q;
  logic                timeout_q;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic accept, cap, space, push, pop, last_run, timeout_hit;

  // Output / control decode
  always_comb begin
    accept      = 1'b0;
    cap         = 1'b0;
    push        = 1'b0;
    space       = (count_q != CNT_W'(FIFO_DEPTH));
    last_run    = (run_idx_q == num_q - 1'b1);
    pop         = (count_q != '0) && res_ready;
    case (state_q)
      IDLE:    accept = start && (num_runs != '0);
      WAIT: begin
        cap  = core_done && !done_q;
        push = cap && space;
      end
      FULLW:   push = space;
      default: ;
    endcase
  end

`ifdef RUN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q;

  assign timeout_hit = (state_q == WAIT) && !cap && (wcnt_q == TW'(TIMEOUT - 1));

  // Counts cycles spent in WAIT; zero on every entry
  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) wcnt_q <= '0;
    else                          wcnt_q <= wcnt_q + 1'b1;
  end
`else
  // Constant low; the comparison only keeps the parameter referenced
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = HOLD;
      HOLD:  if (hold_cnt_q == '0) state_d = WAIT;
      WAIT: begin
        if (cap) begin
          if (!space)        state_d = FULLW;
          else if (last_run) state_d = IDLE;
          else               state_d = HOLD;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      FULLW: if (space) state_d = last_run ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // State register and sequencing datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      num_q          <= '0;
      run_idx_q      <= '0;
      hold_cnt_q     <= '0;
      done_q         <= 1'b0;
      core_rst_n_q   <= 1'b0;
      run_complete_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        num_q     <= num_runs;
        run_idx_q <= '0;
        timeout_q <= 1'b0;
      end else if (push && !last_run) begin
        run_idx_q <= run_idx_q + 1'b1;
      end
      if (timeout_hit) timeout_q <= 1'b1;
      if (state_d == HOLD && state_q != HOLD) hold_cnt_q <= HOLD_W'(RST_CYCLES - 1);
      else if (state_q == HOLD)               hold_cnt_q <= hold_cnt_q - 1'b1;
      // Edge detector only armed in WAIT, so a done already high on entry still captures
      done_q         <= (state_q == WAIT) && core_done;
      core_rst_n_q   <= (state_d == WAIT) || (state_d == FULLW);
      run_complete_q <= (push && last_run) || timeout_hit;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {run_idx_q, core_cycle, core_sum};
  end

  assign res_valid    = (count_q != '0);
  assign res_data     = res_valid ? mem[rd_ptr_q] : '0;
  assign core_reset_n = core_rst_n_q;
  assign busy         = (state_q != IDLE);
  assign run_complete = run_complete_q;
  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mvm_run_sequencer.sv
// Directed bench for mvm_run_sequencer with a behavioural core model and an expected-result queue.
// Build with RUN_TIMEOUT_EN to exercise the watchdog path.
module tb_mvm_run_sequencer;

  localparam int SUM_W = 24;
  localparam int CYC_W = 10;
  localparam int RUNS_W = 8;
  localparam int DW = RUNS_W + CYC_W + SUM_W;
  localparam int TB_TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [RUNS_W-1:0] num_runs = '0;
  logic              core_reset_n;
  logic [SUM_W-1:0]  core_sum = '0;
  logic [CYC_W-1:0]  core_cycle = '0;
  logic              core_done = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DW-1:0]     res_data;
  logic              busy;
  logic              run_complete;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  int core_delay = 200;
  int sum_base = 0;
  bit never_done = 1'b0;
  int rcnt = 0;
  int done_cnt = 0;

  mvm_run_sequencer #(
    .SUM_W(SUM_W), .CYC_W(CYC_W), .RUNS_W(RUNS_W),
    .FIFO_DEPTH(4), .RST_CYCLES(2), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs),
    .core_reset_n(core_reset_n), .core_sum(core_sum), .core_cycle(core_cycle),
    .core_done(core_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .run_complete(run_complete),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Core model: raises done core_delay cycles after release and holds it until reset
  always @(posedge clk) begin
    if (!busy) done_cnt <= 0;
    if (!core_reset_n) begin
      rcnt      <= 0;
      core_done <= 1'b0;
    end else if (!core_done && !never_done) begin
      rcnt <= rcnt + 1;
      if (rcnt + 1 == core_delay) begin
        core_done  <= 1'b1;
        core_sum   <= SUM_W'(sum_base + done_cnt);
        core_cycle <= CYC_W'(core_delay);
        done_cnt   <= done_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int idx, input int d, input int base);
    return {RUNS_W'(idx), CYC_W'(d), SUM_W'(base + idx)};
  endfunction

  // Scoreboard: every accepted transfer is matched against the head of exp_q
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {22'd0, res_data}, 64'd0 - 64'd1);
      else                   chk("res_data", {22'd0, res_data}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic start_batch(input int n);
    drv();
    num_runs = RUNS_W'(n);
    start = 1'b1;
    drv();
    start = 1'b0;
  endtask

  task automatic push_exp(input int n, input int d, input int base);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(i, d, base));
  endtask

  initial begin
    int lo_cnt;
    int waitc;
    int b2b;
    int vseen;
    bit prev_v;

    // Reset
    repeat (2) drv();
    reset = 1'b0;
    cyc();
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_complete", run_complete, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Single run, 200-cycle core, FIFO empty latency
    res_ready = 1'b1; core_delay = 200; sum_base = 24'h00ABCD;
    push_exp(1, 200, 24'h00ABCD);
    start_batch(1);
    chk("t1_busy", busy, 1);
    lo_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (core_reset_n) break;
      lo_cnt++;
    end
    chk("t1_hold_cycles", lo_cnt, 2);
    for (int i = 0; i < 400 && !core_done; i++) cyc();
    chk("t1_done_seen", core_done, 1);
    chk("t1_valid_before", res_valid, 0);
    cyc();
    chk("t1_valid_after", res_valid, 1);
    chk("t1_data", {22'd0, res_data}, {22'd0, 8'd0, 10'h0C8, 24'h00ABCD});
    chk("t1_run_complete", run_complete, 1);
    chk("t1_busy_fall", busy, 0);
    cyc();
    chk("t1_pulse_end", run_complete, 0);
    chk("t1_drained", res_valid, 0);

    // Six runs against a stalled consumer: four queued, fifth parks in FULLW
    res_ready = 1'b0; core_delay = 20; sum_base = 24'h100000;
    push_exp(6, 20, 24'h100000);
    start_batch(6);
    for (int i = 0; i < 500 && dbg_state != 2'd3; i++) cyc();
    chk("t2_fullw", dbg_state, 3);
    chk("t2_core_released", core_reset_n, 1);
    chk("t2_head_valid", res_valid, 1);
    chk("t2_head_data", {22'd0, res_data}, {22'd0, mk(0, 20, 24'h100000)});
    chk("t2_none_popped", exp_q.size(), 6);
    repeat (10) cyc();
    chk("t2_still_fullw", dbg_state, 3);
    drv();
    res_ready = 1'b1;
    for (int i = 0; i < 400 && !run_complete; i++) cyc();
    chk("t2_complete", run_complete, 1);
    repeat (6) cyc();
    chk("t2_all_drained", exp_q.size(), 0);
    chk("t2_fifo_empty", res_valid, 0);

    // num_runs=0 ignored, start while busy ignored
    drv();
    num_runs = '0; start = 1'b1;
    drv();
    start = 1'b0;
    cyc();
    chk("t3_zero_busy", busy, 0);
    chk("t3_zero_core_rst", core_reset_n, 0);
    chk("t3_zero_valid", res_valid, 0);
    core_delay = 30; sum_base = 24'h200000;
    push_exp(2, 30, 24'h200000);
    start_batch(2);
    repeat (10) cyc();
    drv();
    num_runs = 8'd7; start = 1'b1;
    drv();
    start = 1'b0;
    for (int i = 0; i < 300 && !run_complete; i++) cyc();
    chk("t3_complete", run_complete, 1);
    repeat (40) cyc();
    chk("t3_idle_after", busy, 0);
    chk("t3_two_entries", exp_q.size(), 0);

    // Reset asserted in WAIT of run 2
    core_delay = 40; sum_base = 24'h300000;
    push_exp(2, 40, 24'h300000);
    start_batch(4);
    for (int i = 0; i < 400 && !(exp_q.size() == 0 && dbg_state == 2'd2); i++) cyc();
    chk("t4_in_wait_run2", dbg_state, 2);
    repeat (3) cyc();
    drv();
    reset = 1'b1;
    drv();
    reset = 1'b0;
    cyc();
    chk("t4_core_reset_n", core_reset_n, 0);
    chk("t4_res_valid", res_valid, 0);
    chk("t4_res_data", res_data, 0);
    chk("t4_busy", busy, 0);
    chk("t4_run_complete", run_complete, 0);
    chk("t4_state", dbg_state, 0);
    core_delay = 200; sum_base = 24'h00ABCD;
    push_exp(1, 200, 24'h00ABCD);
    start_batch(1);
    for (int i = 0; i < 400 && !run_complete; i++) cyc();
    chk("t4_rerun_complete", run_complete, 1);
    chk("t4_rerun_valid", res_valid, 1);
    repeat (3) cyc();
    chk("t4_rerun_drained", exp_q.size(), 0);

    // Always-ready consumer with short runs: at most one entry resident
    core_delay = 5; sum_base = 24'h500000;
    push_exp(3, 5, 24'h500000);
    start_batch(3);
    b2b = 0; vseen = 0; prev_v = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (res_valid) vseen++;
      if (res_valid && prev_v) b2b++;
      prev_v = res_valid;
      if (run_complete) break;
    end
    repeat (3) begin
      cyc();
      if (res_valid) vseen++;
    end
    chk("t5_no_backlog", b2b, 0);
    chk("t5_entries", vseen, 3);
    chk("t5_drained", exp_q.size(), 0);

    // Core never finishes
    never_done = 1'b1; core_delay = 10;
    start_batch(1);
`ifdef RUN_TIMEOUT_EN
    waitc = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (dbg_state == 2'd2) waitc++;
      if (run_complete) break;
    end
    chk("t6_wait_cycles", waitc, TB_TIMEOUT);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_busy", busy, 0);
    chk("t6_no_entry", res_valid, 0);
    chk("t6_core_reset_n", core_reset_n, 0);
    repeat (5) cyc();
    chk("t6_sticky", timeout_err, 1);
    never_done = 1'b0; sum_base = 24'h600000;
    push_exp(1, 10, 24'h600000);
    start_batch(1);
    chk("t6_cleared_on_start", timeout_err, 0);
    for (int i = 0; i < 100 && !run_complete; i++) cyc();
    chk("t6_recover_complete", run_complete, 1);
`else
    waitc = 0;
    repeat (300) begin
      cyc();
      if (dbg_state == 2'd2) waitc++;
    end
    chk("t6_wait_cycles", waitc > 290, 1);
    chk("t6_busy_held", busy, 1);
    chk("t6_no_timeout", timeout_err, 0);
    chk("t6_core_released", core_reset_n, 1);
    drv();
    reset = 1'b1;
    drv();
    reset = 1'b0;
    never_done = 1'b0;
    cyc();
    chk("t6_recover_idle", busy, 0);
`endif

    repeat (5) cyc();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
